// File: rtl/rat_call_stack.sv
// Return-address stack feeding the RAT program-counter mux FROM_STACK input.
// CALL pushes, RET pops with zero-latency read of the top; sticky OVF/UNF flags.
module rat_call_stack #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 10
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         PUSH,
  input  logic                         POP,
  input  logic [WIDTH-1:0]             PUSH_DATA,
  input  logic                         CLR_ERR,
  output logic [WIDTH-1:0]             FROM_STACK,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT,
  output logic                         EMPTY,
  output logic                         FULL,
  output logic                         OVF,
  output logic                         UNF
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_sp;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic             w_we;
  logic             w_set_ovf;
  logic             w_set_unf;
  logic [CW-1:0]    w_sp_nxt;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == CW'(DEPTH));
  assign w_top_idx = AW'(r_sp - CW'(1));

  // Push+pop on a non-empty stack overwrites the top in place, so it never
  // trips OVF even when full; on an empty stack it degrades to a plain push.
  always_comb begin
    w_we      = 1'b0;
    w_wr_idx  = AW'(r_sp);
    w_sp_nxt  = r_sp;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (PUSH && POP && !w_empty) begin
      w_we     = 1'b1;
      w_wr_idx = w_top_idx;
    end else if (PUSH) begin
      if (w_full) begin
        w_set_ovf = 1'b1;
      end else begin
        w_we     = 1'b1;
        w_sp_nxt = r_sp + CW'(1);
      end
    end else if (POP) begin
      if (w_empty) begin
        w_set_unf = 1'b1;
      end else begin
        w_sp_nxt = r_sp - CW'(1);
      end
    end
  end

  // A new error in the same cycle as CLR_ERR wins, keeping the flag set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_sp  <= w_sp_nxt;
      r_ovf <= w_set_ovf | (r_ovf & ~CLR_ERR);
      r_unf <= w_set_unf | (r_unf & ~CLR_ERR);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_wr_idx] <= PUSH_DATA;
    end
  end

  assign FROM_STACK = w_empty ? '0 : r_mem[w_top_idx];
  assign COUNT      = r_sp;
  assign EMPTY      = w_empty;
  assign FULL       = w_full;
  assign OVF        = r_ovf;
  assign UNF        = r_unf;

endmodule
